// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register saturating pending-write counters, multi-port
// writeback retire, combinational RAW/WAW-depth issue grant, flush, sticky underflow flag.
// Optional macro SCOREBOARD_WB_BYPASS_EN: same-cycle writebacks are subtracted when
// evaluating source hazards, so a retiring producer releases its consumer immediately.

module reg_sb_entry #(
  parameter int CNT_W = 2,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          inc_i,
  input  logic [DW-1:0] dec_i,
  output logic          busy_o,
  output logic          eff_nz_o,
  output logic          full_o,
  output logic          uflow_o
);
  localparam int SW = ((CNT_W > DW) ? CNT_W : DW) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sum, decx;

  always_comb begin
    sum     = SW'(cnt_q) + SW'(inc_i);
    decx    = SW'(dec_i);
    uflow_o = decx > sum;
    cnt_d   = uflow_o ? '0 : CNT_W'(sum - decx);
    if (flush_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign eff_nz_o = SW'(cnt_q) > decx;
`else
  assign eff_nz_o = cnt_q != '0;
`endif
  assign full_o = &cnt_q;
  assign busy_o = cnt_q != '0;
endmodule

module reg_scoreboard #(
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_PORTS   = 2,
  parameter int CNT_W      = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           issue_valid,
  input  logic [REG_ADDR_W-1:0]          issue_rd,
  input  logic                           issue_rd_we,
  input  logic [REG_ADDR_W-1:0]          issue_rs1,
  input  logic                           issue_rs1_en,
  input  logic [REG_ADDR_W-1:0]          issue_rs2,
  input  logic                           issue_rs2_en,
  output logic                           issue_ok,
  input  logic [WB_PORTS-1:0]            wb_valid,
  input  logic [WB_PORTS*REG_ADDR_W-1:0] wb_addr,
  input  logic                           flush,
  output logic [REG_COUNT-1:0]           busy,
  output logic                           err_underflow
);
  localparam int DW = $clog2(WB_PORTS + 1);

  // Entry 0 is never built; every per-register vector starts at 1.
  logic [REG_COUNT-1:1] inc, busy_v, eff_nz, full, uflow, hz1, hz2, hzd;
  logic                 fire, err_q;

  assign fire = issue_valid && issue_ok;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_reg
    logic [DW-1:0] dec;
    always_comb begin
      dec = '0;
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid[p] && wb_addr[p*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r))
          dec = dec + DW'(1);
    end

    // Addresses outside [1, REG_COUNT) never match any entry, so they stay hazard-free.
    assign hz1[r] = issue_rs1_en && issue_rs1 == REG_ADDR_W'(r) && eff_nz[r];
    assign hz2[r] = issue_rs2_en && issue_rs2 == REG_ADDR_W'(r) && eff_nz[r];
    assign hzd[r] = issue_rd_we  && issue_rd  == REG_ADDR_W'(r) && full[r];
    assign inc[r] = fire && issue_rd_we && issue_rd == REG_ADDR_W'(r);

    reg_sb_entry #(.CNT_W(CNT_W), .DW(DW)) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush_i  (flush),
      .inc_i    (inc[r]),
      .dec_i    (dec),
      .busy_o   (busy_v[r]),
      .eff_nz_o (eff_nz[r]),
      .full_o   (full[r]),
      .uflow_o  (uflow[r])
    );
  end

  assign issue_ok = !(|hz1 || |hz2 || |hzd);
  assign busy     = {busy_v, 1'b0};

  // Writebacks are discarded under flush, so they cannot raise the error either.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_q <= 1'b0;
    else if (|uflow && !flush) err_q <= 1'b1;
  end
  assign err_underflow = err_q;
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised register scoreboard sitting between the issuer and the commit/writeback stage of the RV32 core.
- Tracks outstanding writes per architectural register with saturating pending counters, so a register may carry several in-flight writes.
- Accepts multiple writeback ports per cycle.
- Produces a same-cycle combinational issue grant covering RAW and WAW-depth hazards; supports pipeline flush.

Parameters:
- REG_COUNT, 32, number of architectural registers (register 0 hardwired, never tracked).
- REG_ADDR_W, 5, register address width; must satisfy 2^REG_ADDR_W >= REG_COUNT.
- WB_PORTS, 2, number of independent writeback/commit ports.
- CNT_W, 2, pending-counter width; max in-flight writes per register = 2^CNT_W - 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- issue_valid  in  1  issuer presents an instruction this cycle
- issue_rd  in  REG_ADDR_W  destination register
- issue_rd_we  in  1  instruction writes issue_rd
- issue_rs1  in  REG_ADDR_W  source 1
- issue_rs1_en  in  1  source 1 is read
- issue_rs2  in  REG_ADDR_W  source 2
- issue_rs2_en  in  1  source 2 is read
- issue_ok  out  1  combinational grant; issue fires when issue_valid && issue_ok
- wb_valid  in  WB_PORTS  per-port writeback strobe
- wb_addr  in  WB_PORTS*REG_ADDR_W  per-port written register, port i at bits [i*REG_ADDR_W +: REG_ADDR_W]
- flush  in  1  synchronous clear of all pending state
- busy  out  REG_COUNT  registered; bit r = (cnt[r] != 0)
- err_underflow  out  1  sticky; writeback to a register with no pending write

Behaviour:
- Reset (async): all cnt[r] = 0, busy = 0, err_underflow = 0. issue_ok is combinational, so it reads 1 immediately after reset for any request.
- Hazard terms, each using effective count eff[r]:
  - src1_hz = issue_rs1_en && issue_rs1 != 0 && eff[issue_rs1] != 0
  - src2_hz = issue_rs2_en && issue_rs2 != 0 && eff[issue_rs2] != 0
  - dst_hz = issue_rd_we && issue_rd != 0 && cnt[issue_rd] == 2^CNT_W - 1 (uses raw cnt, no bypass)
- issue_ok = !(src1_hz || src2_hz || dst_hz). issue_ok is independent of issue_valid.
- Counter update per register r, per cycle: cnt_next = cnt + inc - dec.
  - inc = 1 if the issue fires with issue_rd_we, issue_rd == r, r != 0.
  - dec = number of ports i with wb_valid[i] && wb_addr[i] == r, r != 0.
  - Simultaneous issue and writeback to the same register: net arithmetic, e.g. cnt = 1 with inc 1, dec 1 gives 1.
- Underflow: if dec > cnt + inc, clamp cnt_next to 0 and set err_underflow (sticky until reset).
- Register 0: writebacks ignored, no error; cnt[0] stays 0.
- Out-of-range addresses (>= REG_COUNT): issue treats them as hazard-free and does not lock them; writebacks to them are ignored.
- flush: next cycle all cnt = 0 and busy = 0. Flush has priority over same-cycle issue and writeback. err_underflow is not cleared by flush.
- busy reflects cnt after the clock edge, i.e. 1-cycle latency from an issue or writeback event.
- Reset asserted mid-operation: everything clears asynchronously; in-flight writebacks after reset release are subject to underflow detection.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN
- Defined: eff[r] = cnt[r] - (same-cycle writebacks to r), floored at 0. A source whose last pending write retires this cycle is granted in the same cycle (the writeback data is forwarded elsewhere).
- Not defined: eff[r] = cnt[r]. The grant arrives one cycle after the retiring writeback.
- dst_hz always uses raw cnt, with or without the macro.

Test Plan:
- Reset release, issue rd=5 rs1=1 rs2=2 valid -> issue_ok=1; next cycle busy[5]=1, cnt[5]=1.
- cnt[5]=1, issue rs1=5 -> issue_ok=0. Writeback wb_addr[0]=5 in the same cycle -> issue_ok=1 with SCOREBOARD_WB_BYPASS_EN, 0 without; either way the next cycle has busy[5]=0 and issue_ok=1.
- CNT_W=2: three issues to rd=7 -> cnt=3; fourth issue rd=7 -> issue_ok=0. Same-cycle issue rd=7 plus wb 7 at cnt=2 -> cnt stays 2.
- Both wb ports write reg 9 in one cycle while cnt[9]=2 -> cnt 0, no error. Both write reg 9 while cnt[9]=1 -> cnt 0, err_underflow=1 and it stays 1 after flush.
- Issue rd=0 and wb_addr=0 -> busy[0] stays 0, err_underflow stays 0. Issue rs1=0 with cnt elsewhere -> issue_ok=1.
- cnt[3]=2, cnt[4]=1, then flush together with issue rd=3 and wb 4 -> next cycle busy=0; rst_n pulsed mid-stream -> all state 0 asynchronously.
